// File: rtl/mem_bus_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory port arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic {CMD_READ = 1'b0, CMD_WRITE = 1'b1} cmd_t;
   localparam logic REQ_M0 = 1'b0;
   localparam logic REQ_M1 = 1'b1;
endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// rr_arbiter_2: two-input round-robin selection; the pointer holds the last served requester
module rr_arbiter_2 import mem_arb_pkg::*; (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       last_grant,
   output logic       gnt_id,
   output logic       gnt_valid
);
   logic ptr;
   always_ff @(posedge clk or negedge reset)
      if (!reset) ptr <= REQ_M1;
      else if (update) ptr <= last_grant;
   always_comb begin
      gnt_valid = |req;
      gnt_id    = &req ? ~ptr : req[1];
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between two requesters, one transaction at a time
module mem_bus_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_read_en,
   input  logic                  m0_write_en,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_ready,
   input  logic                  m1_read_en,
   input  logic                  m1_write_en,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_ready,
   output logic                  mem_read_en,
   output logic                  mem_write_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic                  grant_id,
   output logic                  busy,
   output logic                  timeout_err
);
   localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   state_t                state;
   cmd_t                  cmd, gnt_cmd;
   logic [CW-1:0]         cnt;
   logic [1:0]            req;
   logic                  gnt_id, gnt_valid, expired;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic [DATA_WIDTH-1:0] gnt_wdata, resp_data;
   rr_arbiter_2 u_rr (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .update     (state == RESP),
      .last_grant (grant_id),
      .gnt_id     (gnt_id),
      .gnt_valid  (gnt_valid)
   );
   always_comb begin
      req       = {m1_read_en | m1_write_en, m0_read_en | m0_write_en};
      gnt_cmd   = (gnt_id == REQ_M1 ? m1_write_en : m0_write_en) ? CMD_WRITE : CMD_READ;
      gnt_addr  = gnt_id == REQ_M1 ? m1_addr : m0_addr;
      gnt_wdata = gnt_id == REQ_M1 ? m1_wdata : m0_wdata;
      expired   = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
      resp_data = (mem_ready && cmd == CMD_READ) ? mem_rdata : '0;
      busy      = state != IDLE;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state        <= IDLE;
         cmd          <= CMD_READ;
         cnt          <= '0;
         grant_id     <= REQ_M0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         m0_ready     <= 1'b0;
         m1_ready     <= 1'b0;
         m0_rdata     <= '0;
         m1_rdata     <= '0;
         timeout_err  <= 1'b0;
      end else
         case (state)
            IDLE:
               if (gnt_valid) begin
                  state        <= ACCESS;
                  grant_id     <= gnt_id;
                  cmd          <= gnt_cmd;
                  cnt          <= '0;
                  mem_write_en <= gnt_cmd == CMD_WRITE;
                  mem_read_en  <= gnt_cmd == CMD_READ;
                  mem_addr     <= gnt_addr;
                  mem_wdata    <= gnt_wdata;
               end
            ACCESS:
               // mem_ready wins over an expiring watchdog in the same cycle
               if (mem_ready || expired) begin
                  state        <= RESP;
                  mem_read_en  <= 1'b0;
                  mem_write_en <= 1'b0;
                  if (!mem_ready) timeout_err <= 1'b1;
                  if (grant_id == REQ_M1) begin
                     m1_ready <= 1'b1;
                     m1_rdata <= resp_data;
                  end else begin
                     m0_ready <= 1'b1;
                     m0_rdata <= resp_data;
                  end
               end else cnt <= cnt + 1'b1;
            RESP: begin
               state    <= IDLE;
               m0_ready <= 1'b0;
               m1_ready <= 1'b0;
            end
            default: state <= IDLE;
         endcase
endmodule
